// File: rtl/breakout_timer_pkg.sv
// Shared types and modular-arithmetic helpers for the breakout timing blocks.
package breakout_timer_pkg;

    localparam int DEFAULT_TICK_W = 32;

    localparam logic [DEFAULT_TICK_W-1:0] HALF_RANGE = {1'b1, {(DEFAULT_TICK_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    // (a - b) mod 2^w for any w up to 64; callers truncate to their own width.
    function automatic logic [63:0] mod_diff(input logic [63:0] a, input logic [63:0] b,
                                             input int w);
        logic [63:0] mask;
        mask = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        return (a - b) & mask;
    endfunction

endpackage

// File: rtl/tick_delta.sv
// Combinational tick arithmetic: elapsed time, backward-step detection, and the
// anchor that preserves accrued time across an upstream counter restart.
module tick_delta
    import breakout_timer_pkg::*;
#(
    parameter int TICK_W = DEFAULT_TICK_W
) (
    input  logic [TICK_W-1:0] ticks,
    input  logic [TICK_W-1:0] prev_ticks,
    input  logic [TICK_W-1:0] anchor,
    output logic [TICK_W-1:0] elapsed,
    output logic              backward,
    output logic [TICK_W-1:0] rebased_anchor
);

    localparam logic [TICK_W-1:0] HALF = {1'b1, {(TICK_W-1){1'b0}}};

    logic [TICK_W-1:0] step;
    logic [TICK_W-1:0] accrued;

    // NOTE: every always_comb output is assigned on every path, so no latch is inferred.
    always_comb begin
        elapsed        = TICK_W'(mod_diff(64'(ticks), 64'(anchor), TICK_W));
        step           = TICK_W'(mod_diff(64'(ticks), 64'(prev_ticks), TICK_W));
        accrued        = TICK_W'(mod_diff(64'(prev_ticks), 64'(anchor), TICK_W));
        // A step of half the range or more can only be the counter going backwards.
        backward       = (step >= HALF);
        rebased_anchor = TICK_W'(mod_diff(64'(ticks), 64'(accrued), TICK_W));
    end

endmodule

// File: rtl/frame_pacer.sv
// Frame pacer: blocks the caller until interval_ms ticks have elapsed, then pulses
// done_port with the measured elapsed time. Optional FRAME_PACER_DRIFT_COMP_EN keeps
// successive frames on a drift-free deadline grid.
module frame_pacer
    import breakout_timer_pkg::*;
#(
    parameter int TICK_W     = DEFAULT_TICK_W,
    parameter int INTERVAL_W = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start_port,
    input  logic [INTERVAL_W-1:0] interval_ms,
    input  logic [TICK_W-1:0]     ticks,
    output logic                  done_port,
    output logic [TICK_W-1:0]     out1,
    output logic                  overrun
);

    state_t                  state;
    logic [TICK_W-1:0]       anchor;
    logic [INTERVAL_W-1:0]   interval_q;
    logic [TICK_W-1:0]       prev_ticks;

    logic [TICK_W-1:0]       elapsed;
    logic                    backward;
    logic [TICK_W-1:0]       rebased_anchor;
    logic [TICK_W-1:0]       start_anchor;
    logic [TICK_W-1:0]       interval_ext;

    assign interval_ext = TICK_W'(interval_q);

    tick_delta #(.TICK_W(TICK_W)) u_tick_delta (
        .ticks          (ticks),
        .prev_ticks     (prev_ticks),
        .anchor         (anchor),
        .elapsed        (elapsed),
        .backward       (backward),
        .rebased_anchor (rebased_anchor)
    );

`ifdef FRAME_PACER_DRIFT_COMP_EN
    logic [TICK_W-1:0] last_deadline;
    logic              deadline_valid;
    logic [TICK_W-1:0] since_deadline;

    // Snap to the previous deadline when the caller restarts within one interval of it.
    always_comb begin
        since_deadline = TICK_W'(mod_diff(64'(ticks), 64'(last_deadline), TICK_W));
        if (deadline_valid && (since_deadline < TICK_W'(interval_ms)))
            start_anchor = last_deadline;
        else
            start_anchor = ticks;
    end
`else
    assign start_anchor = ticks;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; the reset is synchronous, so it is tested inside the clocked block.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= IDLE;
            anchor     <= '0;
            interval_q <= '0;
            prev_ticks <= '0;
            done_port  <= 1'b0;
            out1       <= '0;
            overrun    <= 1'b0;
`ifdef FRAME_PACER_DRIFT_COMP_EN
            last_deadline  <= '0;
            deadline_valid <= 1'b0;
`endif
        end else begin
            done_port <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_port) begin
                        interval_q <= interval_ms;
                        anchor     <= start_anchor;
                        prev_ticks <= ticks;
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    prev_ticks <= ticks;
                    if (backward) begin
                        anchor <= rebased_anchor;
                    end else if (elapsed >= interval_ext) begin
                        out1    <= elapsed;
                        overrun <= (elapsed > interval_ext);
                        state   <= DONE;
`ifdef FRAME_PACER_DRIFT_COMP_EN
                        last_deadline  <= anchor + interval_ext;
                        deadline_valid <= 1'b1;
`endif
                    end
                end
                DONE: begin
                    done_port <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/frame_pacer.md
Name: frame_pacer

Overview:
- Bambu-callable frame-pacing IP that sits downstream of the millisecond tick counter in the breakout example.
- Consumes the free-running 32-bit ms tick value and blocks the game loop until the requested interval has elapsed.
- Start/done handshake follows the standard Bambu IP convention.
- Returns the elapsed ms measured when the wait ends, plus an overrun flag for late frames.

Parameters:
- TICK_W, 32, width of the tick input and the elapsed result.
- INTERVAL_W, 16, width of the requested interval in ms.

Ports:
- clock  in  1  system clock.
- reset  in  1  reset, synchronous, active-low.
- start_port  in  1  one-cycle request to begin a wait.
- interval_ms  in  INTERVAL_W  requested wait length; sampled only when start is accepted.
- ticks  in  TICK_W  ms counter from the upstream tick block (out1 of that block).
- done_port  out  1  one-cycle completion pulse.
- out1  out  TICK_W  elapsed ms at completion; held until the next completion.
- overrun  out  1  elapsed > interval at completion; held with out1.

Behaviour:
- Reset (reset==0 at a clock edge):
  - state=IDLE; done_port=0; out1=0; overrun=0.
  - anchor, interval_q and prev_ticks cleared.
  - Reset overrides every other event in the same cycle.
- States: IDLE, WAIT, DONE.
- IDLE:
  - On start_port==1: interval_q<=interval_ms, anchor<=ticks, prev_ticks<=ticks, go to WAIT.
  - Otherwise remain in IDLE.
- WAIT:
  - elapsed = (ticks - anchor) mod 2^TICK_W, computed combinationally.
  - If elapsed >= zero-extended interval_q: out1<=elapsed, overrun<=(elapsed>interval_q), go to DONE.
  - prev_ticks<=ticks every cycle.
- DONE:
  - done_port=1 for exactly this one cycle, then IDLE.
  - start_port seen in DONE is ignored; the caller reissues it.
- Latency: start sampled at edge N; earliest done_port is high in the cycle after edge N+2. This holds for interval_ms=0, with out1=0.
- start_port in WAIT or DONE: ignored; no queueing.
- Counter wrap: all arithmetic is modular TICK_W, so a ticks wrap 0xFFFFFFFF->0 during WAIT is transparent.
- Upstream restart (ticks steps backwards):
  - Detected when (ticks - prev_ticks) mod 2^TICK_W >= 2^(TICK_W-1).
  - Action: anchor<=ticks - (prev_ticks - anchor), so elapsed accumulated so far is preserved.
  - No completion is generated that cycle.
- ticks unchanged for many cycles: remain in WAIT; there is no timeout.
- Reset mid-WAIT: immediate return to IDLE; no done_port pulse.

Optional Feature:
- FRAME_PACER_DRIFT_COMP_EN
- Defined:
  - Block keeps last_deadline = anchor + interval_q, updated at every completion, plus a valid bit cleared on reset.
  - On a new start, if valid and (ticks - last_deadline) mod 2^TICK_W < interval_ms, then anchor<=last_deadline instead of ticks. Frames stay on a drift-free grid.
  - Otherwise anchor<=ticks (resynchronise).
- Undefined: anchor is always ticks at start; no extra registers.

Decomposition:
- Package breakout_timer_pkg holds:
  - state enum {IDLE, WAIT, DONE}.
  - TICK_W default.
  - HALF_RANGE constant, 2^(TICK_W-1).
  - a modular-difference function.
- One sub-module, tick_delta:
  - Inputs: ticks, prev_ticks, anchor.
  - Outputs: elapsed, a backward flag, and the rebased anchor (combinational).
- The FSM and output registers stay in frame_pacer.

Test Plan:
- Reset held 3 cycles, then released -> done_port=0, out1=0, overrun=0; state IDLE.
- interval_ms=16, ticks increments every 4 clocks from 100 -> single done_port pulse when ticks reaches 116, out1=16, overrun=0.
- interval_ms=0 -> done_port in the cycle after edge N+2, out1=0, overrun=0.
- Wrap: start at ticks=0xFFFFFFFE with interval 5; ticks advances to 3 -> done with out1=5.
- Stall and backward step:
  - ticks frozen at 200 for 50 cycles after a start at 190 with interval 20 -> no done; then jump to 215 -> done, out1=25, overrun=1.
  - Separately, ticks drops 150->0 mid-wait (start 140, interval 30) -> elapsed preserved at 10; done when ticks reaches 20.
- FRAME_PACER_DRIFT_COMP_EN:
  - Completion at deadline 116 (start 100, interval 16); restart at ticks=120, interval 16 -> done when ticks=132, out1=16.
  - Without the macro -> done when ticks=136.
